// File: rtl/lsu_pkg.sv
// Shared types, encodings and lane helpers for the load/store sequencer.
package lsu_pkg;

    // Sequencer state encoding.
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_REQ  = 2'd1;
    localparam lsu_state_t ST_RESP = 2'd2;
    localparam lsu_state_t ST_DONE = 2'd3;

    // Load type codes as produced by main decoding.
    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    // Access size codes; identical to the store_type encoding so a store
    // type can be used directly as a size.
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    // Map a load type to its access size; undefined codes map to SZ_BAD.
    function automatic logic [1:0] load_size(input logic [2:0] lt);
        logic [1:0] sz;
        case (lt)
            LT_LB, LT_LBU: sz = SZ_BYTE;
            LT_LH, LT_LHU: sz = SZ_HALF;
            LT_LW:         sz = SZ_WORD;
            default:       sz = SZ_BAD;
        endcase
        return sz;
    endfunction

    // An access is rejected when it is not naturally aligned or its size is undefined.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        logic bad;
        case (sz)
            SZ_WORD: bad = (a != 2'b00);
            SZ_HALF: bad = a[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte enables for an access of the given size at byte offset a.
    function automatic logic [3:0] be_gen(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across every lane so the enabled lanes carry it.
    function automatic logic [31:0] wdata_rep(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] rep;
        case (sz)
            SZ_BYTE: rep = {4{wd[7:0]}};
            SZ_HALF: rep = {2{wd[15:0]}};
            default: rep = wd;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Read-data lane selection and sign/zero extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/halfword and extend it to 32 bits.
    always_comb begin
        case (lane)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        case (load_type)
            LT_LB:   data = {{24{byte_v[7]}}, byte_v};
            LT_LBU:  data = {24'd0, byte_v};
            LT_LH:   data = {{16{half_v[15]}}, half_v};
            LT_LHU:  data = {16'd0, half_v};
            LT_LW:   data = rdata;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one core access, runs it as a single
// req/gnt + rvalid bus transaction, and stalls the core until it finishes.
// Handshake: bus_req is held with stable bus_* fields until a cycle with
// bus_gnt=1; the access then completes on the first cycle with bus_rvalid=1
// (which may be the gnt cycle itself). rvalid at any other time is ignored.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        store_en,
    input  logic [2:0]  load_type,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT);

    lsu_state_t  state;
    lsu_state_t  state_next;
    logic [7:0]  tmo_cnt;
    logic [8:0]  tmo_inc;
    logic [1:0]  lat_lane;
    logic [2:0]  lat_type;
    logic        lat_load;
    logic [1:0]  acc_size;
    logic        access;
    logic        acc_bad;
    logic        accept;
    logic        busy;
    logic        complete;
    logic        tmo_hit;
    logic [31:0] aligned_data;

    // Decode the incoming access and the completion/timeout conditions.
    always_comb begin
        access   = load_en | store_en;
        acc_size = store_en ? store_type : load_size(load_type);
        acc_bad  = misaligned(acc_size, addr[1:0]);
        accept   = (state == ST_IDLE) & access & ~acc_bad;
        busy     = (state == ST_REQ) | (state == ST_RESP);
        complete = ((state == ST_REQ) & bus_gnt & bus_rvalid) |
                   ((state == ST_RESP) & bus_rvalid);
        tmo_inc  = {1'b0, tmo_cnt} + 9'd1;
        tmo_hit  = busy & ~complete & (tmo_inc == TMO_LIMIT);
    end

    // Core-facing status; IDLE terms are gated by reset so every output is 0 in reset.
    always_comb begin
        stall        = rst_n & (accept | busy);
        misalign_err = rst_n & (state == ST_IDLE) & access & acc_bad;
        timeout_err  = tmo_hit;
        bus_req      = (state == ST_REQ);
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_REQ;
            ST_REQ: begin
                if (complete || tmo_hit) state_next = ST_DONE;
                else if (bus_gnt)        state_next = ST_RESP;
            end
            ST_RESP: if (complete || tmo_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Timeout counter: cleared on acceptance, counts every REQ/RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      tmo_cnt <= 8'd0;
        else if (accept) tmo_cnt <= 8'd0;
        else if (busy)   tmo_cnt <= tmo_inc[7:0];
    end

    // Latch bus fields and load formatting info when an access is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            lat_lane  <= 2'd0;
            lat_type  <= 3'd0;
            lat_load  <= 1'b0;
        end else if (accept) begin
            bus_we    <= store_en;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_gen(acc_size, addr[1:0]);
            bus_wdata <= wdata_rep(acc_size, wdata);
            lat_lane  <= addr[1:0];
            lat_type  <= load_type;
            lat_load  <= ~store_en;
        end
    end

    lsu_align u_align (
        .rdata     (bus_rdata),
        .lane      (lat_lane),
        .load_type (lat_type),
        .data      (aligned_data)
    );

    // Capture the formatted load result on completion; an abort returns 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    load_data <= 32'd0;
        else if (tmo_hit)              load_data <= 32'd0;
        else if (complete && lat_load) load_data <= aligned_data;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a driver issues accesses and bus responses, pushing the
// expected outcome into a queue; a monitor pops it when the access finishes.
module tb_lsu_ctrl;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic        store_en;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        timeout_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    lsu_ctrl #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (load_en),
        .store_en     (store_en),
        .load_type    (load_type),
        .store_type   (store_type),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_gnt      (bus_gnt),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          mis;
        bit          is_store;
        bit          tmo;
        int          stall_cyc;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] ldata;
        bit          chk_ld;
    } exp_t;

    exp_t exp_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %0s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // Access size in bytes; 0 marks an undefined type code.
    function automatic int size_of(input bit st, input logic [1:0] stp, input logic [2:0] lt);
        if (st) return (stp == 2'd0) ? 4 : (stp == 2'd1) ? 2 : (stp == 2'd2) ? 1 : 0;
        case (lt)
            3'd0, 3'd3: return 1;
            3'd1, 3'd4: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] ext_load(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] w);
        int     n;
        longint v;
        n = size_of(1'b0, 2'd0, lt);
        v = longint'(w >> (8 * (a % 4)));
        v = v & ((longint'(1) << (8 * n)) - 1);
        if ((lt == 3'd0 || lt == 3'd1) && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            load_en = 1'b0; store_en = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        end
    endtask

    // gd: wait cycles before gnt; rdl: wait cycles after gnt before rvalid;
    // same: rvalid together with gnt. Large gd means gnt never arrives.
    task automatic do_access(input bit ld, input bit st, input logic [2:0] lt, input logic [1:0] stp,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                             input int gd, input int rdl, input bit same, input bit noise);
        exp_t e;
        int   n;
        int   c;
        int   lim;
        bit   real_v;
        @(posedge clk); #1;
        load_en = ld; store_en = st; load_type = lt; store_type = stp;
        addr = a; wdata = wd; bus_gnt = 1'b0;
        bus_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_rdata = $urandom;
        n = size_of(st, stp, lt);
        e = '{default: 0};
        if (n == 0 || (a % n) != 0) begin
            e.mis = 1'b1;
            exp_q.push_back(e);
            @(posedge clk); #1;
            load_en = 1'b0; store_en = 1'b0; bus_rvalid = 1'b0;
            return;
        end
        c   = gd + 1 + (same ? 0 : rdl + 1);
        lim = (c > TMO) ? TMO : c;
        e.is_store  = st;
        e.tmo       = (c > TMO);
        e.stall_cyc = 1 + lim;
        e.baddr     = {a[31:2], 2'b00};
        e.be        = 4'(((1 << n) - 1) << (a % 4));
        e.bwd       = (n == 1) ? wd[7:0] * 32'h0101_0101 :
                      (n == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        e.ldata     = e.tmo ? 32'd0 : ext_load(lt, a, rw);
        e.chk_ld    = e.tmo || !st;
        exp_q.push_back(e);
        for (int k = 1; k <= lim; k++) begin
            @(posedge clk); #1;
            bus_gnt = (k == gd + 1);
            real_v  = same ? (k == gd + 1) : (k == gd + rdl + 2);
            bus_rvalid = real_v || (noise && k <= gd && $urandom_range(0, 1) == 1);
            bus_rdata  = real_v ? rw : $urandom;
        end
        // DONE cycle: enables stay asserted; a late rvalid after an abort.
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        bus_rvalid = e.tmo;
        bus_rdata = $urandom;
    endtask

    // ---------------- monitor ----------------
    int          st_cnt;
    int          tmo_cnt;
    int          tmo_pos;
    bit          prev_stall;
    bit          req_seen;
    bit          unstable;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wd;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            st_cnt = 0; tmo_cnt = 0; tmo_pos = 0;
            prev_stall = 1'b0; req_seen = 1'b0; unstable = 1'b0;
        end else begin
            if (misalign_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_misalign", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("misalign_expected", 32'd1, 32'(e.mis));
                    check("misalign_stall", 32'(stall), 32'd0);
                    check("misalign_bus_req", 32'(bus_req), 32'd0);
                end
            end
            if (stall) begin
                st_cnt++;
                if (timeout_err) begin
                    tmo_cnt++;
                    tmo_pos = st_cnt;
                end
                if (bus_req) begin
                    if (!req_seen) begin
                        req_seen = 1'b1;
                        r_we = bus_we; r_addr = bus_addr; r_be = bus_be; r_wd = bus_wdata;
                    end else if (r_we !== bus_we || r_addr !== bus_addr ||
                                 r_be !== bus_be || r_wd !== bus_wdata) begin
                        unstable = 1'b1;
                    end
                end
            end else if (prev_stall) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("access_not_misaligned", 32'(e.mis), 32'd0);
                    check("stall_cycles", 32'(st_cnt), 32'(e.stall_cyc));
                    check("bus_req_seen", 32'(req_seen), 32'd1);
                    check("bus_we", 32'(r_we), 32'(e.is_store));
                    check("bus_addr", r_addr, e.baddr);
                    check("bus_be", 32'(r_be), 32'(e.be));
                    if (e.is_store) check("bus_wdata", r_wd, e.bwd);
                    check("bus_fields_stable", 32'(unstable), 32'd0);
                    check("timeout_pulses", 32'(tmo_cnt), e.tmo ? 32'd1 : 32'd0);
                    if (e.tmo) check("timeout_cycle", 32'(tmo_pos), 32'(e.stall_cyc));
                    if (e.chk_ld) check("load_data", load_data, e.ldata);
                    check("done_bus_req", 32'(bus_req), 32'd0);
                end
                st_cnt = 0; tmo_cnt = 0; tmo_pos = 0; req_seen = 1'b0; unstable = 1'b0;
            end else begin
                check("idle_quiet", {30'd0, timeout_err, bus_req}, 32'd0);
            end
            prev_stall = stall;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          st;
        bit          ld;
        int          r;
        logic [2:0]  lt;
        logic [1:0]  stp;
        int          gd;

        rst_n = 1'b0;
        load_en = 1'b0; store_en = 1'b0; load_type = 3'd0; store_type = 2'd0;
        addr = 32'd0; wdata = 32'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;

        // Reset state, with a misaligned lh presented to show status is held low.
        repeat (2) @(posedge clk);
        #1;
        load_en = 1'b1; load_type = 3'd1; addr = 32'h101;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        load_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases.
        do_access(1, 0, 3'd2, 2'd0, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        do_access(1, 0, 3'd0, 2'd0, 32'h103, 32'd0, 32'h8012_3456, 0, 0, 0, 0);
        do_access(1, 0, 3'd3, 2'd0, 32'h103, 32'd0, 32'h8012_3456, 0, 0, 0, 0);
        do_access(0, 1, 3'd0, 2'd2, 32'h102, 32'h0000_00A5, 32'd0, 2, 0, 0, 0);
        do_access(1, 0, 3'd1, 2'd0, 32'h101, 32'd0, 32'd0, 0, 0, 0, 0);
        do_access(1, 0, 3'd2, 2'd0, 32'h204, 32'd0, 32'h1234_5678, 0, 0, 1, 0);
        do_access(1, 0, 3'd2, 2'd0, 32'h040, 32'd0, 32'h5555_AAAA, 100, 0, 0, 0);
        do_access(1, 0, 3'd4, 2'd0, 32'h102, 32'd0, 32'h8001_7FFF, 1, 1, 0, 0);
        do_access(1, 0, 3'd1, 2'd0, 32'h102, 32'd0, 32'h8001_7FFF, 0, 1, 0, 0);
        do_access(0, 1, 3'd0, 2'd1, 32'h306, 32'hCAFE_1234, 32'd0, 0, 0, 1, 0);
        do_access(0, 1, 3'd0, 2'd3, 32'h300, 32'hCAFE_1234, 32'd0, 0, 0, 0, 0);
        idle(2);

        // Reset while the access waits for rvalid.
        @(posedge clk); #1;
        load_en = 1'b1; load_type = 3'd2; addr = 32'h200; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_bus_req", 32'(bus_req), 32'd0);
        check("midrst_bus_addr", bus_addr, 32'd0);
        check("midrst_bus_be", 32'(bus_be), 32'd0);
        check("midrst_load_data", load_data, 32'd0);
        load_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_access(1, 0, 3'd2, 2'd0, 32'h200, 32'd0, 32'h0BAD_F00D, 0, 0, 0, 0);

        // Randomized accesses, many back-to-back.
        for (int i = 0; i < 120; i++) begin
            r   = $urandom_range(0, 9);
            st  = (r < 4);
            ld  = (r >= 3);
            lt  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            stp = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            gd  = ($urandom_range(0, 7) == 0) ? 50 : $urandom_range(0, 4);
            do_access(ld, st, lt, stp, $urandom, $urandom, $urandom,
                      gd, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the single-cycle core's control path and a handshaked data-memory bus. It accepts the load/store controls produced by main decoding, checks alignment, drives one bus transaction per access, and stalls the core until the access completes. It also formats write data and byte enables, extracts and extends read data, and flags misalignment and bus timeout.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in REQ+RESP before abort; range 1–255.
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `load_en`  in  1  current instruction is a load (ResultSrc==01)
- `store_en`  in  1  current instruction is a store (MemWrite)
- `load_type`  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
- `store_type`  in  2  00 word, 01 half, 10 byte
- `addr`  in  32  ALU-computed byte address
- `wdata`  in  32  store data (rs2)
- `stall`  out  1  hold PC/pipeline state
- `load_data`  out  32  extended load result, valid in DONE
- `misalign_err`  out  1  one-cycle pulse
- `timeout_err`  out  1  one-cycle pulse
- `bus_req`  out  1  request
- `bus_we`  out  1  1 = write
- `bus_addr`  out  32  word-aligned address ({addr[31:2],2'b00})
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  lane-replicated store data
- `bus_gnt`  in  1  request accepted
- `bus_rvalid`  in  1  response (read data / write ack)
- `bus_rdata`  in  32  read word

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: access = load_en|store_en; store_en has priority if both are set.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0; undefined type codes also count): misalign_err=1 this cycle; no bus activity; stall=0; remain IDLE.
  - Aligned: stall=1 combinationally; latch we, addr, be, wdata, type; go to REQ.
- REQ: bus_req=1; latched bus signals held stable until gnt.
  - On gnt: go to RESP.
  - On gnt & rvalid in the same cycle: capture and go to DONE.
- RESP: bus_req=0. On rvalid: capture load_data (loads) and go to DONE. rvalid outside RESP, or outside a gnt cycle in REQ, is ignored.
- DONE: stall=0; load_data valid; return to IDLE unconditionally. The still-present load_en/store_en is not re-accepted.
- Timeout: an 8-bit counter clears on IDLE→REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT without completion: timeout_err pulses, load_data=0, go to DONE, bus_req drops.
  - A late rvalid after this is ignored.
- Byte enables: byte → 4'b0001<<addr[1:0]; half → 4'b0011<<{addr[1],1'b0}; word → 4'b1111.
- bus_wdata: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load extract: lane from addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Reset values: state IDLE, counter 0; stall, bus_req, bus_we, misalign_err, timeout_err = 0; bus_addr, bus_be, bus_wdata, load_data = 0.
- Reset mid-transaction abandons the access immediately; bus_req drops asynchronously.

## Timing
- Zero-wait bus (gnt in the first REQ cycle, rvalid the next cycle):
  - T0: IDLE accepts, stall=1.
  - T1: REQ gnt, stall=1.
  - T2: RESP rvalid, stall=1.
  - T3: DONE, stall=0.
- Stall therefore lasts 3 cycles minimum; each wait cycle on gnt or rvalid adds one.
- With gnt and rvalid in the same cycle, stall lasts 2 cycles.
- Misaligned accesses: 0 stall cycles.
- All bus outputs are registered except bus_req, which is decoded from state.
- Back-to-back accesses: the next instruction may be accepted in the IDLE cycle directly following DONE.

## Structure
- Package `lsu_pkg`:
  - state enum
  - load_type/store_type localparams
  - functions `be_gen(type, addr[1:0])` and `wdata_rep(type, wdata)`
- Sub-module `lsu_align`: combinational lane select and sign/zero extension (bus_rdata, addr[1:0], load_type → load_data).
- FSM, latches and timeout counter live in lsu_ctrl.

## Test plan
- lw at addr 0x100, gnt in T1, rvalid in T2 with rdata 0xDEADBEEF → stall high for exactly 3 cycles; load_data=0xDEADBEEF in DONE; bus_be=1111.
- lb at 0x103 with rdata 0x80xxxxxx → bus_addr 0x100, be 1000, load_data 0xFFFFFF80. The same access as lbu → load_data 0x00000080.
- Store byte 0xA5 to 0x102, gnt delayed 2 cycles → bus_we=1, be 0100, wdata 0xA5A5A5A5, signals stable through the wait; stall lasts 5 cycles.
- lh at 0x101 → misalign_err pulses 1 cycle; no bus_req; stall never asserts.
- TIMEOUT=4, gnt never returned → timeout_err pulses on the 4th REQ cycle; load_data=0; stall releases in DONE. A later rvalid is ignored.
- rst_n asserted during RESP → bus_req, stall and all outputs 0 immediately; after release, a new lw completes normally.
